// File: rtl/mmu_table_ctrl.sv
// mmu_table_ctrl: page-table RAM controller for a user-mode MMU.
// It serves translation reads and supervisor writes of the frame table.
// The optional background clear engine is compiled in only when the
// macro MMU_TABLE_CLEAR_EN is defined. Without it, clr_busy is tied low
// and clr_req/clr_map are ignored.
// Handshake: a requester raises *_req with stable operands and holds it
// until the matching *_ack. The ack then stays high until the requester
// drops *_req, and the controller returns to IDLE on that edge.
module mmu_table_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        xlat_req,
  input  logic [3:0]  xlat_map,
  input  logic [11:0] xlat_page,
  output logic        xlat_ack,
  output logic [15:0] xlat_frame,
  input  logic        wr_req,
  input  logic [3:0]  wr_map,
  input  logic [11:0] wr_page,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  input  logic        clr_req,
  input  logic [3:0]  clr_map,
  output logic        clr_busy,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

`ifdef MMU_TABLE_CLEAR_EN
  typedef enum logic [2:0] {IDLE, RD, RD_DONE, WR, WR_DONE, CLR} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD, RD_DONE, WR, WR_DONE} state_t;
`endif

  state_t      r_state;
  logic        r_xlat_ack;
  logic [15:0] r_xlat_frame;
  logic        r_wr_ack;
  logic [15:0] r_ram_addr;
  logic [15:0] r_ram_wdata;
  logic        r_ram_oe_n;
  logic        r_ram_we_n;

`ifdef MMU_TABLE_CLEAR_EN
  logic [3:0]  r_clr_map;
  logic [11:0] r_clr_cnt;
  logic        r_clr_busy;
  logic        w_clr_more;
  logic [11:0] w_clr_idx;

  // Next clear step to issue. While in CLR the step in flight is r_clr_cnt,
  // so the one after it is r_clr_cnt+1 and none remain after 0xFFF.
  always_comb begin
    w_clr_more = r_clr_busy;
    w_clr_idx  = r_clr_cnt;
    if (r_state == CLR) begin
      w_clr_more = (r_clr_cnt != 12'hFFF);
      w_clr_idx  = r_clr_cnt + 12'd1;
    end
  end

  assign clr_busy = r_clr_busy;
`else
  logic w_unused_clr;
  assign w_unused_clr = ^{clr_req, clr_map};
  assign clr_busy     = 1'b0;
`endif

  assign xlat_ack   = r_xlat_ack;
  assign xlat_frame = r_xlat_frame;
  assign wr_ack     = r_wr_ack;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign ram_oe_n   = r_ram_oe_n;
  assign ram_we_n   = r_ram_we_n;

  // Controller FSM with registered RAM strobes, acks and clear bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_xlat_ack   <= 1'b0;
      r_xlat_frame <= 16'h0000;
      r_wr_ack     <= 1'b0;
      r_ram_addr   <= 16'h0000;
      r_ram_wdata  <= 16'h0000;
      r_ram_oe_n   <= 1'b1;
      r_ram_we_n   <= 1'b1;
`ifdef MMU_TABLE_CLEAR_EN
      r_clr_map    <= 4'h0;
      r_clr_cnt    <= 12'h000;
      r_clr_busy   <= 1'b0;
`endif
    end else begin
      case (r_state)
        RD: begin
          r_xlat_frame <= ram_rdata;
          r_xlat_ack   <= 1'b1;
          r_ram_oe_n   <= 1'b1;
          r_state      <= RD_DONE;
        end
        RD_DONE: begin
          if (!xlat_req) begin
            r_xlat_ack <= 1'b0;
            r_state    <= IDLE;
          end
        end
        WR: begin
          r_ram_we_n <= 1'b1;
          r_wr_ack   <= 1'b1;
          r_state    <= WR_DONE;
        end
        WR_DONE: begin
          if (!wr_req) begin
            r_wr_ack <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          // IDLE (and CLR, which re-arbitrates so clear steps run back to back)
          r_ram_oe_n <= 1'b1;
          r_ram_we_n <= 1'b1;
          r_state    <= IDLE;
          if (xlat_req) begin
            r_ram_addr <= {xlat_map, xlat_page};
            r_ram_oe_n <= 1'b0;
            r_state    <= RD;
          end else if (wr_req) begin
            r_ram_addr  <= {wr_map, wr_page};
            r_ram_wdata <= wr_data;
            r_ram_we_n  <= 1'b0;
            r_state     <= WR;
          end
`ifdef MMU_TABLE_CLEAR_EN
          else if (w_clr_more) begin
            r_ram_addr  <= {r_clr_map, w_clr_idx};
            r_ram_wdata <= 16'h0000;
            r_ram_we_n  <= 1'b0;
            r_state     <= CLR;
          end
`endif
        end
      endcase
`ifdef MMU_TABLE_CLEAR_EN
      // A finished step advances the counter; the last one ends the clear.
      if (r_state == CLR) begin
        if (r_clr_cnt == 12'hFFF) begin
          r_clr_busy <= 1'b0;
        end else begin
          r_clr_cnt <= r_clr_cnt + 12'd1;
        end
      end else if (clr_req && !r_clr_busy) begin
        r_clr_map  <= clr_map;
        r_clr_cnt  <= 12'h000;
        r_clr_busy <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mmu_table_ctrl.sv
// tb_mmu_table_ctrl: scoreboard bench for mmu_table_ctrl.
// Covers the clear engine when MMU_TABLE_CLEAR_EN is defined; otherwise it
// checks that clr_req has no effect.
module tb_mmu_table_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        xlat_req;
  logic [3:0]  xlat_map;
  logic [11:0] xlat_page;
  logic        xlat_ack;
  logic [15:0] xlat_frame;
  logic        wr_req;
  logic [3:0]  wr_map;
  logic [11:0] wr_page;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        clr_req;
  logic [3:0]  clr_map;
  logic        clr_busy;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_oe_n;
  logic        ram_we_n;

  // clock
  always #5 clk = ~clk;

  mmu_table_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .xlat_req   (xlat_req),
    .xlat_map   (xlat_map),
    .xlat_page  (xlat_page),
    .xlat_ack   (xlat_ack),
    .xlat_frame (xlat_frame),
    .wr_req     (wr_req),
    .wr_map     (wr_map),
    .wr_page    (wr_page),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .clr_req    (clr_req),
    .clr_map    (clr_map),
    .clr_busy   (clr_busy),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_oe_n   (ram_oe_n),
    .ram_we_n   (ram_we_n)
  );

  // table RAM (async read) and the reference table (what RAM should hold)
  logic [15:0] mem [0:65535];
  logic [15:0] model_mem [0:65535];
  logic        fill_go = 1'b0;
  logic [3:0]  fill_map = 4'h0;

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (fill_go) begin
      for (int i = 0; i < 4096; i++) mem[{fill_map, i[11:0]}] <= model_mem[{fill_map, i[11:0]}];
    end else if (!ram_we_n) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic [15:0] exp_q[$];
  logic [31:0] exp_wr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: pops expected frames on ack rise and expected writes on each write cycle
  initial begin
    logic prev_ack;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      chk("oe_we_exclusive", {31'd0, ram_oe_n | ram_we_n}, 32'd1);
      if (xlat_ack && !prev_ack) begin
        if (exp_q.size() == 0) chk("xlat_unexpected_ack", 32'd1, 32'd0);
        else chk("xlat_frame", {16'd0, xlat_frame}, {16'd0, exp_q.pop_front()});
      end
      prev_ack = xlat_ack;
      if (!ram_we_n) begin
        we_cnt++;
        if (exp_wr_q.size() == 0) chk("ram_unexpected_write", {ram_addr, ram_wdata}, 32'hxxxx_xxxx);
        else chk("ram_write", {ram_addr, ram_wdata}, exp_wr_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic push_map(input logic [3:0] m);
    fill_map = m;
    fill_go  = 1'b1;
    @(negedge clk);
    fill_go  = 1'b0;
  endtask

  task automatic do_xlat(input logic [3:0] m, input logic [11:0] p);
    int lat = 1;
    xlat_map  = m;
    xlat_page = p;
    xlat_req  = 1'b1;
    exp_q.push_back(model_mem[{m, p}]);
    @(negedge clk);
    chk("xlat_rd_oe", {31'd0, ram_oe_n}, 32'd0);
    chk("xlat_rd_addr", {16'd0, ram_addr}, {16'd0, m, p});
    while (!xlat_ack && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("xlat_ack_latency", lat, 2);
    xlat_req = 1'b0;
    @(negedge clk);
    chk("xlat_ack_drop", {31'd0, xlat_ack}, 32'd0);
  endtask

  task automatic do_wr(input logic [3:0] m, input logic [11:0] p, input logic [15:0] d);
    int lat = 0;
    wr_map  = m;
    wr_page = p;
    wr_data = d;
    wr_req  = 1'b1;
    exp_wr_q.push_back({m, p, d});
    model_mem[{m, p}] = d;
    do begin
      @(negedge clk);
      lat++;
    end while (!wr_ack && lat < 20);
    chk("wr_ack_latency", lat, 2);
    wr_req = 1'b0;
    @(negedge clk);
    chk("wr_ack_drop", {31'd0, wr_ack}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_xlat_ack"}, {31'd0, xlat_ack}, 32'd0);
    chk({tag, "_wr_ack"}, {31'd0, wr_ack}, 32'd0);
    chk({tag, "_clr_busy"}, {31'd0, clr_busy}, 32'd0);
    chk({tag, "_xlat_frame"}, {16'd0, xlat_frame}, 32'd0);
    chk({tag, "_ram_addr"}, {16'd0, ram_addr}, 32'd0);
    chk({tag, "_ram_wdata"}, {16'd0, ram_wdata}, 32'd0);
    chk({tag, "_ram_oe_n"}, {31'd0, ram_oe_n}, 32'd1);
    chk({tag, "_ram_we_n"}, {31'd0, ram_we_n}, 32'd1);
  endtask

  // watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish actual=running required=done");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // main stimulus
  initial begin
    logic [3:0]  m;
    logic [11:0] p;
    int          lat;
    int          base;
    int          bad;
    int          n;
    xlat_req = 1'b0; xlat_map = 4'h0; xlat_page = 12'h000;
    wr_req = 1'b0; wr_map = 4'h0; wr_page = 12'h000; wr_data = 16'h0000;
    clr_req = 1'b0; clr_map = 4'h0;

    // preload every map with random frames while reset is held
    for (int mi = 0; mi < 16; mi++) begin
      for (int pi = 0; pi < 4096; pi++) model_mem[{mi[3:0], pi[11:0]}] = 16'($urandom);
      if (mi == 1) model_mem[16'h1002] = 16'h8123;
      push_map(mi[3:0]);
    end
    chk_reset_outputs("reset");

    // translation issued on the very edge that first sees reset released
    reset_n = 1'b1;
    do_xlat(4'd1, 12'h002);

    // write then read back
    do_wr(4'd4, 12'h002, 16'h3C00);
    do_xlat(4'd4, 12'h002);

    // simultaneous requests: translation wins, write waits for xlat_req to drop
    xlat_map = 4'd7; xlat_page = 12'h010;
    wr_map = 4'd8; wr_page = 12'h020; wr_data = 16'h5A5A;
    exp_q.push_back(model_mem[16'h7010]);
    exp_wr_q.push_back(32'h8020_5A5A);
    model_mem[16'h8020] = 16'h5A5A;
    xlat_req = 1'b1; wr_req = 1'b1;
    @(negedge clk);
    chk("simul_rd_first_oe", {31'd0, ram_oe_n}, 32'd0);
    chk("simul_rd_first_we", {31'd0, ram_we_n}, 32'd1);
    lat = 1;
    while (!xlat_ack && lat < 20) begin @(negedge clk); lat++; end
    chk("simul_xlat_latency", lat, 2);
    repeat (2) @(negedge clk);
    chk("simul_wr_held_ack", {31'd0, wr_ack}, 32'd0);
    xlat_req = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!wr_ack && lat < 20);
    chk("simul_wr_latency", lat, 3);
    wr_req = 1'b0;
    @(negedge clk);

    // randomized mix of writes and translations over a small page window
    for (int k = 0; k < 60; k++) begin
      m = 4'($urandom_range(0, 15));
      p = 12'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) do_wr(m, p, 16'($urandom));
      else do_xlat(m, p);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef MMU_TABLE_CLEAR_EN
    // clear pass 1: uninterrupted clear of map 2, map 3 must survive
    for (int pi = 0; pi < 4096; pi++) begin
      model_mem[{4'd2, pi[11:0]}] = 16'hFFFF;
      model_mem[{4'd3, pi[11:0]}] = 16'hFFFF;
    end
    push_map(4'd2);
    push_map(4'd3);
    for (int pi = 0; pi < 4096; pi++) begin
      exp_wr_q.push_back({4'd2, pi[11:0], 16'h0000});
      model_mem[{4'd2, pi[11:0]}] = 16'h0000;
    end
    clr_map = 4'd2; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 10000) begin n++; @(negedge clk); end
    chk("clr_busy_cycles", n, 4097);
    bad = 0;
    for (int pi = 0; pi < 4096; pi++) if (mem[{4'd2, pi[11:0]}] !== 16'h0000) bad++;
    chk("clr_map2_zeroed", bad, 0);
    bad = 0;
    for (int pi = 0; pi < 4096; pi++) if (mem[{4'd3, pi[11:0]}] !== 16'hFFFF) bad++;
    chk("clr_map3_untouched", bad, 0);
    do_xlat(4'd2, 12'($urandom_range(0, 4095)));
    do_xlat(4'd3, 12'($urandom_range(0, 4095)));

    // clear pass 2: translation interleaved at step 0x100, a second clr_req ignored
    for (int pi = 0; pi < 4096; pi++) model_mem[{4'd2, pi[11:0]}] = 16'hFFFF;
    push_map(4'd2);
    for (int pi = 0; pi < 4096; pi++) begin
      exp_wr_q.push_back({4'd2, pi[11:0], 16'h0000});
      model_mem[{4'd2, pi[11:0]}] = 16'h0000;
    end
    base = we_cnt;
    clr_map = 4'd2; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while ((we_cnt - base) < 'h100 && n < 10000) begin @(negedge clk); #1; n++; end
    chk("clr2_reached_step_100", {31'd0, (we_cnt - base) >= 'h100}, 32'd1);
    do_xlat(4'd2, 12'($urandom_range(0, 'hFE)));
    clr_map = 4'd3; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 10000) begin n++; @(negedge clk); end
    chk("clr2_done", {31'd0, clr_busy}, 32'd0);
    chk("clr2_step_count", we_cnt - base, 4096);
    bad = 0;
    for (int pi = 0; pi < 4096; pi++) if (mem[{4'd2, pi[11:0]}] !== 16'h0000) bad++;
    chk("clr2_map2_zeroed", bad, 0);
    do_xlat(4'd3, 12'($urandom_range(0, 4095)));

    // clear pass 3: map 5 aborted by reset while step 0x800 is on the bus
    for (int pi = 0; pi < 4096; pi++) model_mem[{4'd5, pi[11:0]}] = 16'hFFFF;
    push_map(4'd5);
    for (int pi = 0; pi < 4096; pi++) exp_wr_q.push_back({4'd5, pi[11:0], 16'h0000});
    base = we_cnt;
    clr_map = 4'd5; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while ((we_cnt - base) < 'h801 && n < 10000) begin @(negedge clk); #1; n++; end
    chk("clr3_reached_step_800", {31'd0, (we_cnt - base) >= 'h801}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    exp_wr_q.delete();
    for (int pi = 0; pi < 'h800; pi++) model_mem[{4'd5, pi[11:0]}] = 16'h0000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("clr3_no_resume", {31'd0, clr_busy}, 32'd0);
    bad = 0;
    for (int pi = 0; pi < 4096; pi++) if (mem[{4'd5, pi[11:0]}] !== model_mem[{4'd5, pi[11:0]}]) bad++;
    chk("clr3_partial_contents", bad, 0);
    do_xlat(4'd5, 12'h900);
    do_xlat(4'd5, 12'h100);
`else
    // without the clear engine clr_req must do nothing
    base = we_cnt;
    clr_map = 4'd2; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (clr_busy !== 1'b0) bad++;
    end
    chk("noclr_busy_low", bad, 0);
    chk("noclr_no_writes", we_cnt - base, 0);
    do_xlat(4'd2, 12'h005);
`endif

    repeat (2) @(negedge clk);
    chk("xlat_queue_drained", exp_q.size(), 0);
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
